// File: rtl/bit_stream_deframer.sv
// bit_stream_deframer: serial-to-word receiver. Hunts for SYNC_WORD, then emits
// FRAME_LEN payload words per frame and re-checks the sync word between frames.
// Ports:
//   CLK, RST_N        clock, async active-low reset
//   DIN, DIN_DV       serial bit and its valid
//   DOUT, DOUT_DV     payload word (MSB = first bit) and one-cycle valid pulse
//   SOF               first payload word of a frame (with DOUT_DV)
//   LOCKED            high outside HUNT
//   SYNC_ERR          one-cycle pulse on a failed between-frame sync check
module bit_stream_deframer #(
   parameter int unsigned       WORD_W    = 8,
   parameter logic [WORD_W-1:0] SYNC_WORD = WORD_W'(8'hA5),
   parameter int unsigned       FRAME_LEN = 4,
   parameter int unsigned       MISS_MAX  = 2
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              DIN,
   input  logic              DIN_DV,
   output logic [WORD_W-1:0] DOUT,
   output logic              DOUT_DV,
   output logic              SOF,
   output logic              LOCKED,
   output logic              SYNC_ERR
);

   localparam int unsigned BW = $clog2(WORD_W);
   localparam int unsigned CW = $clog2(FRAME_LEN) + 1;
   localparam int unsigned MW = $clog2(MISS_MAX) + 1;

   localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_W - 1);
   localparam logic [CW-1:0] WORD_LAST = CW'(FRAME_LEN - 1);
   localparam logic [MW-1:0] MISS_LAST = MW'(MISS_MAX - 1);

   typedef enum logic [1:0] {
      S_HUNT    = 2'd0,
      S_PAYLOAD = 2'd1,
      S_CHECK   = 2'd2
   } state_t;

   state_t            r_state;
   logic [WORD_W-1:0] r_sr;
   logic [BW-1:0]     r_bit_cnt;
   logic [CW-1:0]     r_word_cnt;
   logic [MW-1:0]     r_miss_cnt;
   logic [WORD_W-1:0] r_dout;
   logic              r_dout_dv;
   logic              r_sof;
   logic              r_sync_err;

   logic [WORD_W-1:0] w_nxt;
   logic              w_match;
   logic              w_last_bit;

   assign w_nxt      = {r_sr[WORD_W-2:0], DIN};
   assign w_match    = (w_nxt == SYNC_WORD);
   assign w_last_bit = (r_bit_cnt == BIT_LAST);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state    <= S_HUNT;
         r_sr       <= '0;
         r_bit_cnt  <= '0;
         r_word_cnt <= '0;
         r_miss_cnt <= '0;
         r_dout     <= '0;
         r_dout_dv  <= 1'b0;
         r_sof      <= 1'b0;
         r_sync_err <= 1'b0;
      end else begin
         r_dout_dv  <= 1'b0;
         r_sof      <= 1'b0;
         r_sync_err <= 1'b0;
         if (DIN_DV) begin
            // shifting continues in every state so HUNT slides over old bits
            r_sr <= w_nxt;
            unique case (r_state)
               S_HUNT: begin
                  if (w_match) begin
                     r_state    <= S_PAYLOAD;
                     r_bit_cnt  <= '0;
                     r_word_cnt <= '0;
                     r_miss_cnt <= '0;
                  end
               end
               S_PAYLOAD: begin
                  if (w_last_bit) begin
                     r_dout    <= w_nxt;
                     r_dout_dv <= 1'b1;
                     r_sof     <= (r_word_cnt == '0);
                     r_bit_cnt <= '0;
                     if (r_word_cnt == WORD_LAST) begin
                        r_word_cnt <= '0;
                        r_state    <= S_CHECK;
                     end else begin
                        r_word_cnt <= r_word_cnt + 1'b1;
                     end
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                  end
               end
               S_CHECK: begin
                  if (w_last_bit) begin
                     r_bit_cnt <= '0;
                     if (w_match) begin
                        r_miss_cnt <= '0;
                        r_state    <= S_PAYLOAD;
                     end else begin
                        r_sync_err <= 1'b1;
                        if (r_miss_cnt == MISS_LAST) begin
                           r_miss_cnt <= '0;
                           r_state    <= S_HUNT;
                        end else begin
                           // flywheel: treat the next frame as payload anyway
                           r_miss_cnt <= r_miss_cnt + 1'b1;
                           r_state    <= S_PAYLOAD;
                        end
                     end
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                  end
               end
               default: r_state <= S_HUNT;
            endcase
         end
      end
   end

   assign DOUT     = r_dout;
   assign DOUT_DV  = r_dout_dv;
   assign SOF      = r_sof;
   assign SYNC_ERR = r_sync_err;
   assign LOCKED   = (r_state != S_HUNT);

endmodule

// File: tb/tb_bit_stream_deframer.sv
// tb_bit_stream_deframer: directed and random stimulus against a
// frame-position reference model of the deframer.
module tb_bit_stream_deframer;

   localparam int W  = 8;
   localparam int FL = 4;
   localparam int MM = 2;
   localparam logic [7:0] SYNC = 8'hA5;

   logic       CLK;
   logic       RST_N;
   logic       DIN;
   logic       DIN_DV;
   logic [7:0] DOUT;
   logic       DOUT_DV;
   logic       SOF;
   logic       LOCKED;
   logic       SYNC_ERR;

   bit_stream_deframer #(
      .WORD_W(W), .SYNC_WORD(SYNC), .FRAME_LEN(FL), .MISS_MAX(MM)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .DIN(DIN), .DIN_DV(DIN_DV),
      .DOUT(DOUT), .DOUT_DV(DOUT_DV), .SOF(SOF),
      .LOCKED(LOCKED), .SYNC_ERR(SYNC_ERR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_vec = 0;
   int n_err = 0;
   int n_serr = 0;
   logic [7:0] q_got[$];
   logic       q_sof[$];

   // reference model: lock flag plus bit position within a
   // (FRAME_LEN payload words + 1 sync word) superframe
   logic [7:0] m_win;
   logic [7:0] m_dout;
   bit m_locked, m_dv, m_sof, m_err;
   int m_pos, m_miss;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s @%0t got %0h exp %0h", tag, $time, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_win = '0; m_dout = '0;
      m_locked = 0; m_dv = 0; m_sof = 0; m_err = 0;
      m_pos = 0; m_miss = 0;
   endtask

   task automatic m_step(input logic din, input logic dv);
      m_dv = 0; m_sof = 0; m_err = 0;
      if (!RST_N) begin
         m_reset();
         return;
      end
      if (!dv) return;
      m_win = {m_win[6:0], din};
      if (!m_locked) begin
         if (m_win == SYNC) begin
            m_locked = 1; m_pos = 0; m_miss = 0;
         end
      end else begin
         m_pos++;
         if (m_pos <= FL * W && m_pos % W == 0) begin
            m_dv = 1; m_dout = m_win; m_sof = (m_pos == W);
         end
         if (m_pos == (FL + 1) * W) begin
            m_pos = 0;
            if (m_win != SYNC) begin
               m_err = 1;
               m_miss++;
               if (m_miss == MM) begin
                  m_locked = 0; m_miss = 0;
               end
            end else begin
               m_miss = 0;
            end
         end
      end
   endtask

   task automatic step(input logic din, input logic dv);
      DIN = din; DIN_DV = dv;
      @(posedge CLK); #1;
      m_step(din, dv);
      if (DOUT_DV) begin
         q_got.push_back(DOUT);
         q_sof.push_back(SOF);
      end
      if (SYNC_ERR) n_serr++;
      chk("dout_dv", 32'(DOUT_DV), 32'(m_dv));
      chk("sof", 32'(SOF), 32'(m_sof));
      chk("sync_err", 32'(SYNC_ERR), 32'(m_err));
      chk("locked", 32'(LOCKED), 32'(m_locked));
      chk("dout", 32'(DOUT), 32'(m_dout));
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      for (int i = 7; i >= 0; i--) begin
         step(b[i], 1'b1);
         repeat (gap) step(1'($urandom), 1'b0);
      end
   endtask

   task automatic do_reset();
      RST_N = 1'b0;
      #1;
      m_reset();
      repeat (2) step(1'($urandom), 1'($urandom));
      RST_N = 1'b1;
      q_got.delete();
      q_sof.delete();
      n_serr = 0;
   endtask

   task automatic chk_frame(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
      logic [7:0] e[4];
      e[0] = a; e[1] = b; e[2] = c; e[3] = d;
      chk("n_words", 32'(q_got.size()), 32'd4);
      if (q_got.size() >= 4)
         for (int i = 0; i < 4; i++) begin
            chk("word", 32'(q_got[i]), 32'(e[i]));
            chk("word_sof", 32'(q_sof[i]), 32'(i == 0));
         end
   endtask

   task automatic s2_stream(input int gap);
      send_byte(8'h00, gap);
      q_got.delete(); q_sof.delete();
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      send_byte(8'hA5, gap);
      chk("lock_rise", 32'(LOCKED), 32'd1);
      send_byte(8'h12, gap);
      send_byte(8'h34, gap);
      send_byte(8'h56, gap);
      send_byte(8'h78, gap);
      chk_frame(8'h12, 8'h34, 8'h56, 8'h78);
   endtask

   initial begin
      RST_N = 1'b0; DIN = 1'b0; DIN_DV = 1'b0;
      m_reset();
      #1;
      // 1: reset with random input, then idle zeros
      repeat (10) step(1'($urandom), 1'($urandom));
      RST_N = 1'b1;
      repeat (20) step(1'b0, 1'b1);
      chk("s1_nowords", 32'(q_got.size()), 32'd0);

      // 2: continuous lock and payload
      do_reset();
      s2_stream(0);

      // 3: same stream, valid one cycle in three
      do_reset();
      s2_stream(2);

      // 4: flywheel miss then loss of lock
      do_reset();
      send_byte(8'hA5, 0);
      repeat (4) send_byte(8'($urandom), 0);
      send_byte(8'h00, 0);
      chk("s4_err1", 32'(n_serr), 32'd1);
      chk("s4_lock", 32'(LOCKED), 32'd1);
      q_got.delete(); q_sof.delete();
      send_byte(8'h9A, 0);
      send_byte(8'hBC, 0);
      send_byte(8'hDE, 0);
      send_byte(8'hF0, 0);
      chk_frame(8'h9A, 8'hBC, 8'hDE, 8'hF0);
      send_byte(8'h00, 0);
      chk("s4_err2", 32'(n_serr), 32'd2);
      chk("s4_unlock", 32'(LOCKED), 32'd0);
      repeat (4) send_byte(8'h00, 0);

      // 5: a good sync between misses clears the miss count
      do_reset();
      send_byte(8'hA5, 0);
      repeat (4) send_byte(8'h3C, 0);
      send_byte(8'h00, 0);
      repeat (4) send_byte(8'h3C, 0);
      send_byte(8'hA5, 0);
      repeat (4) send_byte(8'h3C, 0);
      send_byte(8'h00, 0);
      chk("s5_err", 32'(n_serr), 32'd2);
      chk("s5_lock", 32'(LOCKED), 32'd1);

      // 6: asynchronous reset mid-word
      do_reset();
      send_byte(8'hA5, 0);
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      #2;
      RST_N = 1'b0;
      #1;
      chk("s6_dout", 32'(DOUT), 32'd0);
      chk("s6_dv", 32'(DOUT_DV), 32'd0);
      chk("s6_sof", 32'(SOF), 32'd0);
      chk("s6_lock", 32'(LOCKED), 32'd0);
      chk("s6_err", 32'(SYNC_ERR), 32'd0);
      m_reset();
      repeat (2) step(1'($urandom), 1'($urandom));
      RST_N = 1'b1;
      q_got.delete(); q_sof.delete();
      send_byte(8'hA5, 0);
      send_byte(8'h11, 0);
      chk("s6_n", 32'(q_got.size()), 32'd1);
      if (q_got.size() >= 1) begin
         chk("s6_word", 32'(q_got[0]), 32'h11);
         chk("s6_wsof", 32'(q_sof[0]), 32'd1);
      end

      // random traffic with frequent sync words and random gaps
      do_reset();
      for (int k = 0; k < 250; k++) begin
         if ($urandom_range(0, 3) == 0)
            send_byte(8'hA5, $urandom_range(0, 2));
         else
            send_byte(8'($urandom), $urandom_range(0, 2));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/bit_stream_deframer.md
# bit_stream_deframer

Single-clock receiver that turns a 1-bit serial stream with a per-bit valid into framed parallel words. It sits on the read side of the team's 1-bit clock-domain-crossing FIFO: that FIFO's data and data-valid outputs drive this block's DIN / DIN_DV. The block hunts for a sync word, then emits FRAME_LEN payload words per frame. It re-checks the sync word between frames and tolerates up to MISS_MAX-1 consecutive sync misses before dropping lock.

## Interface
- WORD_W, 8: payload and sync word width in bits; legal range 4..32.
- SYNC_WORD, 8'hA5: WORD_W-bit frame alignment pattern.
- FRAME_LEN, 4: payload words per frame; must be >= 1.
- MISS_MAX, 2: consecutive sync misses that force loss of lock; must be >= 1.
- CLK  in  1  single clock; all logic on its rising edge.
- RST_N  in  1  asynchronous, active-low reset. Assertion is asynchronous; release is synchronous to CLK and is handled externally.
- DIN  in  1  serial data bit; sampled only when DIN_DV=1.
- DIN_DV  in  1  DIN valid; any gap pattern is legal.
- DOUT  out  WORD_W  assembled payload word; the first received bit is the MSB.
- DOUT_DV  out  1  one-cycle pulse; DOUT is valid while it is high.
- SOF  out  1  high together with DOUT_DV on the first payload word of each frame.
- LOCKED  out  1  high in every state except HUNT.
- SYNC_ERR  out  1  one-cycle pulse when a between-frame sync check fails.

## Operation
- Shift register `sr` (WORD_W bits): on every DIN_DV=1 cycle, `sr <= {sr[WORD_W-2:0], DIN}`. Define `nxt = {sr[WORD_W-2:0], DIN}`.
- Counters:
  - `bit_cnt`: clog2(WORD_W) bits.
  - `word_cnt`: clog2(FRAME_LEN)+1 bits.
  - `miss_cnt`: clog2(MISS_MAX)+1 bits.
  - None of them wraps except by the explicit clears listed below.
- States: HUNT, PAYLOAD, CHECK. Reset state is HUNT.
- HUNT, on DIN_DV with `nxt == SYNC_WORD`:
  - go to PAYLOAD;
  - clear bit_cnt, word_cnt and miss_cnt.
  - Matching is bit-sliding: every valid bit is tested, including bits shifted in before HUNT was entered.
- PAYLOAD, on each DIN_DV:
  - increment bit_cnt.
  - When bit_cnt == WORD_W-1: register DOUT <= nxt, pulse DOUT_DV, set SOF = (word_cnt == 0), clear bit_cnt, increment word_cnt.
  - If that word was word FRAME_LEN-1: go to CHECK and clear word_cnt.
- CHECK: count WORD_W valid bits. On the WORD_W-th bit:
  - Match (`nxt == SYNC_WORD`): miss_cnt <= 0, go to PAYLOAD.
  - Mismatch: pulse SYNC_ERR. If miss_cnt+1 == MISS_MAX, go to HUNT with miss_cnt <= 0. Otherwise miss_cnt++ and go to PAYLOAD (flywheel: the next WORD_W*FRAME_LEN bits are emitted as payload).
- Sync words are never presented on DOUT.
- DIN is ignored whenever DIN_DV=0. Counters and state hold during gaps.
- MISS_MAX=1: the first mismatch returns the block to HUNT.

## Timing
- Reset values: DOUT=0, DOUT_DV=0, SOF=0, LOCKED=0, SYNC_ERR=0. Internally sr=0, all counters 0, state HUNT.
- Reset asserted mid-word or mid-frame discards the partial word and the frame position. Outputs go to reset values immediately (asynchronously).
- Latency: DOUT_DV, SOF and SYNC_ERR go high in the cycle after the CLK edge that sampled the completing bit. They are high for exactly one cycle.
- DOUT holds its last value between pulses.
- LOCKED:
  - rises in the cycle after the edge that samples the final sync bit in HUNT;
  - falls in the cycle after the edge that samples the bit completing the MISS_MAX-th failing check.
  - SYNC_ERR and the LOCKED fall occur in the same cycle.
- With continuous DIN_DV, consecutive DOUT_DV pulses are WORD_W cycles apart. Across a CHECK, the gap is 2*WORD_W cycles.
- No back-pressure: the downstream consumer must accept a word on every DOUT_DV pulse.

## Test plan
All scenarios use WORD_W=8, SYNC_WORD=8'hA5, FRAME_LEN=4, MISS_MAX=2 unless stated.

1. Reset: RST_N=0 while driving random DIN/DIN_DV -> all outputs stay 0. Release, then feed 20 bits of 0 -> LOCKED remains 0 and no DOUT_DV.
2. Lock and payload, continuous DIN_DV: feed bits 0,1,1, then A5, 12, 34, 56, 78 (MSB first).
   - LOCKED=1 one cycle after the last A5 bit.
   - DOUT = 12, 34, 56, 78, with DOUT_DV pulses 8 cycles apart and SOF only with 12.
3. Gapped input: same stream as scenario 2 with DIN_DV high 1 cycle in 3 -> identical words and SOF. Each DOUT_DV is a single-cycle pulse.
4. Flywheel miss:
   - After one locked frame, send 00 in place of A5, then 9A, BC, DE, F0 -> SYNC_ERR pulses once, LOCKED stays 1, and the four words are output.
   - Then send 00 again -> second SYNC_ERR, LOCKED=0 in the same cycle, and no DOUT_DV until a new A5 arrives.
5. Miss recovery: frame, bad sync (00), frame, good A5, frame, bad sync (00) -> LOCKED never falls, because miss_cnt was cleared by the good A5. SYNC_ERR pulses twice.
6. Reset mid-word: while locked, pull RST_N low after 3 payload bits.
   - Outputs go to 0 immediately.
   - After release, re-sending A5 followed by 11 gives DOUT=11 with SOF=1.
